// File: rtl/prng_checker.sv
// Self-synchronising checker for an 8-bit LFSR stream: seeds, locks, flags deviations, counts errors.
// oError/oErrCount/oLocked update one edge after the valid sample; always ready, no backpressure.
module prng_checker #(
    parameter int N        = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic         clk,
    input  logic         iResetN,
    input  logic         iValid,
    input  logic [N-1:0] iData,
    input  logic         iClearErr,
    output logic         oLocked,
    output logic         oError,
    output logic [15:0]  oErrCount,
    output logic [N-1:0] oExpected
);

    typedef enum logic [1:0] {SEEK, HUNT, LOCKED} state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
        return {x[N-2:0], x[N-1] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    state_t       state, state_n;
    logic [N-1:0] pred, pred_n;
    logic [3:0]   match_cnt, match_cnt_n;
    logic [3:0]   miss_cnt, miss_cnt_n;
    logic         err, err_n;
    logic [15:0]  err_cnt, err_cnt_n;
    logic [3:0]   match_inc;
    logic [3:0]   miss_inc;
    logic         hit;

    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;
    assign hit       = (iData == pred);

    always_comb begin
        state_n     = state;
        pred_n      = pred;
        match_cnt_n = match_cnt;
        miss_cnt_n  = miss_cnt;
        err_n       = 1'b0;
        err_cnt_n   = err_cnt;
        if (iValid) begin
            case (state)
                SEEK: begin
                    // The all-zero word is the LFSR lock-up state and can never seed a predictor.
                    if (iData != '0) begin
                        pred_n      = lfsr_next(iData);
                        match_cnt_n = 4'd0;
                        state_n     = HUNT;
                    end
                end
                HUNT: begin
                    if (hit) begin
                        pred_n      = lfsr_next(iData);
                        match_cnt_n = match_inc;
                        if (match_inc == LOCK_LIM) begin
                            state_n    = LOCKED;
                            miss_cnt_n = 4'd0;
                        end
                    end else begin
                        match_cnt_n = 4'd0;
                        if (iData != '0) begin
                            pred_n = lfsr_next(iData);
                        end else begin
                            pred_n  = '0;
                            state_n = SEEK;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked the predictor free-runs and ignores the sampled data.
                    pred_n = lfsr_next(pred);
                    if (hit) begin
                        miss_cnt_n = 4'd0;
                    end else begin
                        err_n      = 1'b1;
                        miss_cnt_n = miss_inc;
                        if (err_cnt != 16'hFFFF) begin
                            err_cnt_n = err_cnt + 16'd1;
                        end
                        if (miss_inc == LOSS_LIM) begin
                            state_n     = SEEK;
                            pred_n      = '0;
                            match_cnt_n = 4'd0;
                            miss_cnt_n  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_n = SEEK;
                    pred_n  = '0;
                end
            endcase
        end
        if (iClearErr) begin
            err_cnt_n = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge iResetN) begin
        if (!iResetN) begin
            state     <= SEEK;
            pred      <= '0;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            err       <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            match_cnt <= match_cnt_n;
            miss_cnt  <= miss_cnt_n;
            err       <= err_n;
            err_cnt   <= err_cnt_n;
        end
    end

    assign oLocked   = (state == LOCKED);
    assign oError    = err;
    assign oErrCount = err_cnt;
    assign oExpected = pred;

endmodule

// File: tb/tb_prng_checker.sv
// Directed bench for prng_checker; a second instance (fast lock, slow loss) exercises counter saturation.
module tb_prng_checker;

    logic        clk;
    logic        iResetN;
    logic        iValid;
    logic [7:0]  iData;
    logic        iClearErr;
    logic        oLocked;
    logic        oError;
    logic [15:0] oErrCount;
    logic [7:0]  oExpected;

    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_clear;
    logic        s_locked;
    logic        s_error;
    logic [15:0] s_count;
    logic [7:0]  s_expected;

    int n_chk  = 0;
    int n_fail = 0;

    prng_checker #(.N(8), .LOCK_CNT(4), .LOSS_CNT(3)) u_dut (
        .clk       (clk),
        .iResetN   (iResetN),
        .iValid    (iValid),
        .iData     (iData),
        .iClearErr (iClearErr),
        .oLocked   (oLocked),
        .oError    (oError),
        .oErrCount (oErrCount),
        .oExpected (oExpected)
    );

    prng_checker #(.N(8), .LOCK_CNT(1), .LOSS_CNT(15)) u_sat (
        .clk       (clk),
        .iResetN   (iResetN),
        .iValid    (s_valid),
        .iData     (s_data),
        .iClearErr (s_clear),
        .oLocked   (s_locked),
        .oError    (s_error),
        .oErrCount (s_count),
        .oExpected (s_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk);
        iValid    = v;
        iData     = d;
        iClearErr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic [7:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    logic [7:0] seq [5];
    logic [7:0] exp_seq [5];
    logic [7:0] s;

    initial begin
        seq     = '{8'h1F, 8'h3E, 8'h7D, 8'hFB, 8'hF6};
        exp_seq = '{8'h3E, 8'h7D, 8'hFB, 8'hF6, 8'hED};
        iResetN = 1'b0; iValid = 1'b0; iData = 8'h00; iClearErr = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_clear = 1'b0;
        #12;
        check("rst_locked", 32'(oLocked), 32'd0);
        check("rst_error", 32'(oError), 32'd0);
        check("rst_count", 32'(oErrCount), 32'd0);
        check("rst_expected", 32'(oExpected), 32'd0);
        @(negedge clk);
        iResetN = 1'b1;

        // Initial acquisition
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i], 1'b0);
            check("acq_expected", 32'(oExpected), 32'(exp_seq[i]));
            check("acq_locked", 32'(oLocked), (i == 4) ? 32'd1 : 32'd0);
        end
        check("acq_count", 32'(oErrCount), 32'd0);

        // Single lock-up word while locked
        step(1'b1, 8'h00, 1'b0);
        check("zero_error", 32'(oError), 32'd1);
        check("zero_count", 32'(oErrCount), 32'd1);
        check("zero_locked", 32'(oLocked), 32'd1);
        check("zero_expected", 32'(oExpected), 32'hDB);
        step(1'b1, 8'hDB, 1'b0);
        check("pulse_width", 32'(oError), 32'd0);
        step(1'b1, 8'hB7, 1'b0);
        step(1'b1, 8'h6F, 1'b0);
        check("flywheel_expected", 32'(oExpected), 32'hDE);
        // Two misses must not unlock if the earlier miss was cleared by matches
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        check("two_miss_locked", 32'(oLocked), 32'd1);
        check("two_miss_count", 32'(oErrCount), 32'd3);
        check("two_miss_expected", 32'(oExpected), 32'h7A);
        step(1'b1, 8'h7A, 1'b0);
        check("recover_expected", 32'(oExpected), 32'hF5);
        check("recover_error", 32'(oError), 32'd0);

        // Clear while idle, hold with iValid low
        step(1'b0, 8'h55, 1'b1);
        check("clear_count", 32'(oErrCount), 32'd0);
        check("idle_expected", 32'(oExpected), 32'hF5);
        check("idle_locked", 32'(oLocked), 32'd1);

        // Loss of lock
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hAA, 1'b0);
            check("loss_error", 32'(oError), 32'd1);
            check("loss_count", 32'(oErrCount), 32'(i + 1));
            check("loss_locked", 32'(oLocked), (i == 2) ? 32'd0 : 32'd1);
        end
        check("loss_expected", 32'(oExpected), 32'd0);

        // Hunt behaviour: mismatches reseed, never count
        step(1'b1, 8'hAA, 1'b0);
        check("hunt_seed_expected", 32'(oExpected), 32'h55);
        check("hunt_seed_error", 32'(oError), 32'd0);
        step(1'b1, 8'h11, 1'b0);
        check("hunt_reseed_expected", 32'(oExpected), 32'h23);
        check("hunt_miss_error", 32'(oError), 32'd0);
        check("hunt_miss_count", 32'(oErrCount), 32'd3);
        step(1'b1, 8'h00, 1'b0);
        check("hunt_zero_expected", 32'(oExpected), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i], 1'b0);
            check("relock_locked", 32'(oLocked), (i == 4) ? 32'd1 : 32'd0);
        end
        check("relock_expected", 32'(oExpected), 32'hED);

        // Asynchronous reset mid-stream while oError is high
        step(1'b1, 8'h01, 1'b0);
        check("pre_rst_error", 32'(oError), 32'd1);
        check("pre_rst_count", 32'(oErrCount), 32'd4);
        #2;
        iResetN = 1'b0;
        iValid  = 1'b0;
        #1;
        check("arst_locked", 32'(oLocked), 32'd0);
        check("arst_error", 32'(oError), 32'd0);
        check("arst_count", 32'(oErrCount), 32'd0);
        check("arst_expected", 32'(oExpected), 32'd0);
        @(negedge clk);
        iResetN = 1'b1;

        // Leading zeros are ignored, then a fresh acquisition
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check("zeros_expected", 32'(oExpected), 32'd0);
        check("zeros_locked", 32'(oLocked), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i], 1'b0);
            check("fresh_expected", 32'(oExpected), 32'(exp_seq[i]));
            check("fresh_locked", 32'(oLocked), (i == 4) ? 32'd1 : 32'd0);
        end

        // Clear coinciding with a locked mismatch: clear wins, pulse still fires
        step(1'b1, 8'hAA, 1'b1);
        check("clr_coincide_error", 32'(oError), 32'd1);
        check("clr_coincide_count", 32'(oErrCount), 32'd0);
        step(1'b1, 8'h00, 1'b0);
        check("post_clr_count", 32'(oErrCount), 32'd1);
        check("post_clr_locked", 32'(oLocked), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("idle_error", 32'(oError), 32'd0);

        // Saturation on the second instance
        sstep(8'h1F);
        check("sat_seed_expected", 32'(s_expected), 32'h3E);
        sstep(8'h3E);
        check("sat_locked", 32'(s_locked), 32'd1);
        s = 8'h7D;
        for (int r = 0; r < 4700; r++) begin
            for (int k = 0; k < 14; k++) begin
                sstep(s ^ 8'h01);
                s = nxt(s);
            end
            sstep(s);
            s = nxt(s);
            if (r == 0) check("sat_first_round", 32'(s_count), 32'd14);
        end
        check("sat_count", 32'(s_count), 32'hFFFF);
        check("sat_still_locked", 32'(s_locked), 32'd1);
        sstep(s ^ 8'h01);
        check("sat_error", 32'(s_error), 32'd1);
        check("sat_hold", 32'(s_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
